rename_table_wide: RTL and testbench

- Parametrised register renamer: maps ARCH_REGS architectural registers onto PHYS_REGS physical registers for up to WIDTH instructions per cycle.
- Keeps a speculative map, a committed (retirement) map, and speculative and committed free bitmaps.
- Sits between decode and issue; retire feeds back from the ROB.
- Extends the single-lane renamer with: multi-lane allocation and intra-group bypass, multi-lane retire, flush recovery to committed state, and a free count.

---
 rtl/rename_pkg.sv | 15 +
 rtl/rename_table_wide_if.sv | 42 ++++
 rtl/freelist_picker.sv | 31 +++
 rtl/rename_table_wide.sv | 169 ++++++++++++++++
 tb/tb_rename_table_wide.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared defaults and types for the wide register renamer.
package rename_pkg;

  localparam int unsigned DEF_ARCH_REGS = 16;
  localparam int unsigned DEF_PHYS_REGS = 32;
  localparam int unsigned DEF_WIDTH     = 2;

  localparam int unsigned AW = $clog2(DEF_ARCH_REGS);
  localparam int unsigned PW = $clog2(DEF_PHYS_REGS);

  typedef logic [AW-1:0]            arch_reg_t;
  typedef logic [PW-1:0]            phys_reg_t;
  typedef logic [DEF_PHYS_REGS-1:0] free_mask_t;

endpackage

// File: rtl/rename_table_wide_if.sv
// Rename / retire / flush bundle between decode, the renamer and the ROB.
interface rename_table_wide_if
  import rename_pkg::*;
#(
  parameter int unsigned ARCH_REGS = DEF_ARCH_REGS,
  parameter int unsigned PHYS_REGS = DEF_PHYS_REGS,
  parameter int unsigned WIDTH     = DEF_WIDTH
);
  localparam int unsigned ArchW = $clog2(ARCH_REGS);
  localparam int unsigned PhysW = $clog2(PHYS_REGS);

  logic                             ena;
  logic [WIDTH-1:0]                 rn_valid;
  logic [WIDTH-1:0][ArchW-1:0]      rn_src1;
  logic [WIDTH-1:0][ArchW-1:0]      rn_src2;
  logic [WIDTH-1:0][ArchW-1:0]      rn_dst;
  logic [WIDTH-1:0]                 rn_dst_ena;
  logic                             rn_ready;
  logic [WIDTH-1:0][PhysW-1:0]      rn_psrc1;
  logic [WIDTH-1:0][PhysW-1:0]      rn_psrc2;
  logic [WIDTH-1:0][PhysW-1:0]      rn_pdst;
  logic [WIDTH-1:0][PhysW-1:0]      rn_pold;
  logic [WIDTH-1:0]                 rt_valid;
  logic [WIDTH-1:0][ArchW-1:0]      rt_dst;
  logic [WIDTH-1:0][PhysW-1:0]      rt_pdst;
  logic [WIDTH-1:0][PhysW-1:0]      rt_pold;
  logic                             flush;
  logic [PhysW:0]                   free_count;

  modport master (
    output ena, rn_valid, rn_src1, rn_src2, rn_dst, rn_dst_ena,
    output rt_valid, rt_dst, rt_pdst, rt_pold, flush,
    input  rn_ready, rn_psrc1, rn_psrc2, rn_pdst, rn_pold, free_count
  );

  modport slave (
    input  ena, rn_valid, rn_src1, rn_src2, rn_dst, rn_dst_ena,
    input  rt_valid, rt_dst, rt_pdst, rt_pold, flush,
    output rn_ready, rn_psrc1, rn_psrc2, rn_pdst, rn_pold, free_count
  );

endinterface

// File: rtl/freelist_picker.sv
// WIDTH-way lowest-clear-bit selector over the claimed bitmap.
module freelist_picker
  import rename_pkg::*;
#(
  parameter int unsigned PHYS_REGS = DEF_PHYS_REGS,
  parameter int unsigned WIDTH     = DEF_WIDTH
) (
  input  logic [PHYS_REGS-1:0]                    claimed_i,
  output logic [WIDTH-1:0][$clog2(PHYS_REGS)-1:0] idx_o,
  output logic [WIDTH-1:0]                        found_o
);

  logic [PHYS_REGS-1:0] mask;

  // Each slot takes the lowest bit still clear after earlier slots marked theirs.
  always_comb begin
    mask    = claimed_i;
    idx_o   = '0;
    found_o = '0;
    for (int s = 0; s < WIDTH; s++) begin
      for (int i = PHYS_REGS - 1; i >= 0; i--) begin
        if (!mask[i]) begin
          idx_o[s]   = ($clog2(PHYS_REGS))'(i);
          found_o[s] = 1'b1;
        end
      end
      if (found_o[s]) mask[idx_o[s]] = 1'b1;
    end
  end

endmodule

// File: rtl/rename_table_wide.sv
// Multi-lane register renamer: speculative + committed maps and claimed bitmaps,
// intra-group bypass, multi-lane retire, flush to committed state.
// Optional macro RENAME_ZERO_REG_EN: architectural register 0 is never renamed.
module rename_table_wide
  import rename_pkg::*;
#(
  parameter int unsigned ARCH_REGS = DEF_ARCH_REGS,
  parameter int unsigned PHYS_REGS = DEF_PHYS_REGS,
  parameter int unsigned WIDTH     = DEF_WIDTH
) (
  input logic               clk,
  input logic               rst,
  rename_table_wide_if.slave bus
);

  localparam int unsigned ArchW = $clog2(ARCH_REGS);
  localparam int unsigned PhysW = $clog2(PHYS_REGS);
  localparam int unsigned CntW  = PhysW + 1;
  localparam int unsigned SlotW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PHYS_REGS-1:0] ResetMask =
    {{(PHYS_REGS - ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};

  if (PHYS_REGS < ARCH_REGS + WIDTH) begin : g_param_check
    $fatal(1, "PHYS_REGS must be at least ARCH_REGS + WIDTH");
  end

  logic [PhysW-1:0]     spec_map_q [ARCH_REGS];
  logic [PhysW-1:0]     spec_map_d [ARCH_REGS];
  logic [PhysW-1:0]     com_map_q  [ARCH_REGS];
  logic [PhysW-1:0]     com_map_d  [ARCH_REGS];
  logic [PHYS_REGS-1:0] spec_claimed_q, spec_claimed_d;
  logic [PHYS_REGS-1:0] com_claimed_q, com_claimed_d;

  logic [WIDTH-1:0][PhysW-1:0] pick_idx;
  logic [WIDTH-1:0]            pick_found;

  logic [WIDTH-1:0]            alloc;
  logic [CntW-1:0]             need;
  logic [CntW-1:0]             claimed_cnt;
  logic [CntW-1:0]             free_cnt;
  logic [SlotW-1:0]            slot;
  logic [WIDTH-1:0][PhysW-1:0] psrc1, psrc2, pdst, pold;
  logic                        rn_ready;
  logic                        accept;

  // Picker reads the registered bitmap, so same-cycle frees are not reused.
  freelist_picker #(
    .PHYS_REGS(PHYS_REGS),
    .WIDTH    (WIDTH)
  ) u_picker (
    .claimed_i(spec_claimed_q),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  // Free entries in the speculative bitmap.
  always_comb begin
    claimed_cnt = '0;
    for (int i = 0; i < PHYS_REGS; i++) claimed_cnt = claimed_cnt + CntW'(spec_claimed_q[i]);
    free_cnt = CntW'(PHYS_REGS) - claimed_cnt;
  end

  // Lane allocation, then source / old-mapping lookup with intra-group bypass.
  always_comb begin
    alloc = '0;
    need  = '0;
    slot  = '0;
    psrc1 = '0;
    psrc2 = '0;
    pdst  = '0;
    pold  = '0;
    for (int j = 0; j < WIDTH; j++) begin
      alloc[j] = bus.rn_valid[j] & bus.rn_dst_ena[j];
`ifdef RENAME_ZERO_REG_EN
      if (bus.rn_dst[j] == '0) alloc[j] = 1'b0;
`endif
      if (alloc[j]) begin
        pdst[j] = pick_found[slot] ? pick_idx[slot] : '0;
        slot    = slot + 1'b1;
        need    = need + 1'b1;
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (bus.rn_valid[j]) begin
        psrc1[j] = spec_map_q[bus.rn_src1[j]];
        psrc2[j] = spec_map_q[bus.rn_src2[j]];
        if (alloc[j]) pold[j] = spec_map_q[bus.rn_dst[j]];
        // Ascending scan lets the highest earlier writer win.
        for (int k = 0; k < j; k++) begin
          if (alloc[k]) begin
            if (bus.rn_dst[k] == bus.rn_src1[j]) psrc1[j] = pdst[k];
            if (bus.rn_dst[k] == bus.rn_src2[j]) psrc2[j] = pdst[k];
            if (alloc[j] && (bus.rn_dst[k] == bus.rn_dst[j])) pold[j] = pdst[k];
          end
        end
`ifdef RENAME_ZERO_REG_EN
        if (bus.rn_src1[j] == '0) psrc1[j] = '0;
        if (bus.rn_src2[j] == '0) psrc2[j] = '0;
`endif
      end
    end
  end

  // Group handshake: all-or-nothing, flush blocks rename.
  always_comb begin
    rn_ready = (free_cnt >= need) & ~bus.flush;
    accept   = bus.ena & rn_ready & (|bus.rn_valid);
  end

  // Next state: rename commit, retire updates, then flush overrides speculative state.
  always_comb begin
    spec_map_d     = spec_map_q;
    com_map_d      = com_map_q;
    spec_claimed_d = spec_claimed_q;
    com_claimed_d  = com_claimed_q;
    if (accept) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (alloc[j]) begin
          spec_map_d[bus.rn_dst[j]] = pdst[j];
          spec_claimed_d[pdst[j]]   = 1'b1;
        end
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (bus.rt_valid[j]) begin
        com_map_d[bus.rt_dst[j]]       = bus.rt_pdst[j];
        com_claimed_d[bus.rt_pdst[j]]  = 1'b1;
        com_claimed_d[bus.rt_pold[j]]  = 1'b0;
        spec_claimed_d[bus.rt_pold[j]] = 1'b0;
      end
    end
    if (bus.flush) begin
      spec_map_d     = com_map_d;
      spec_claimed_d = com_claimed_d;
    end
`ifdef RENAME_ZERO_REG_EN
    spec_claimed_d[0] = 1'b1;
    com_claimed_d[0]  = 1'b1;
`endif
  end

  // State registers; reset restores identity maps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map_q[i] <= PhysW'(i);
        com_map_q[i]  <= PhysW'(i);
      end
      spec_claimed_q <= ResetMask;
      com_claimed_q  <= ResetMask;
    end else begin
      spec_map_q     <= spec_map_d;
      com_map_q      <= com_map_d;
      spec_claimed_q <= spec_claimed_d;
      com_claimed_q  <= com_claimed_d;
    end
  end

  assign bus.rn_ready   = rn_ready;
  assign bus.rn_psrc1   = psrc1;
  assign bus.rn_psrc2   = psrc2;
  assign bus.rn_pdst    = pdst;
  assign bus.rn_pold    = pold;
  assign bus.free_count = free_cnt;

  logic unused_arch_w;
  assign unused_arch_w = (ArchW == 0);

endmodule

// File: tb/tb_rename_table_wide.sv
// Self-checking bench for rename_table_wide: directed scenarios plus random
// traffic against a sequential-rename reference model with a ROB queue.
module tb_rename_table_wide;
  import rename_pkg::*;

  localparam int AR = DEF_ARCH_REGS;
  localparam int PR = DEF_PHYS_REGS;
  localparam int W  = DEF_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rename_table_wide_if #(.ARCH_REGS(AR), .PHYS_REGS(PR), .WIDTH(W)) bus ();

  rename_table_wide #(.ARCH_REGS(AR), .PHYS_REGS(PR), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_spec_map[AR];
  int m_com_map[AR];
  int g_map[AR];
  bit m_spec_cl[PR];
  bit m_com_cl[PR];
  int e_psrc1[W], e_psrc2[W], e_pdst[W], e_pold[W];
  int e_free;
  bit e_ready;

  typedef struct {int dst; int pdst; int pold;} rob_t;
  rob_t rob[$];

  function automatic void model_reset();
    for (int a = 0; a < AR; a++) begin
      m_spec_map[a] = a;
      m_com_map[a] = a;
    end
    for (int p = 0; p < PR; p++) begin
      m_spec_cl[p] = (p < AR);
      m_com_cl[p] = (p < AR);
    end
  endfunction

  // Rename lanes one after another against a running copy of the map.
  function automatic void model_expect();
    int freeq[$];
    int nalloc;
    int slot;
    nalloc = 0;
    slot = 0;
    for (int p = 0; p < PR; p++) if (!m_spec_cl[p]) freeq.push_back(p);
    e_free = freeq.size();
    for (int j = 0; j < W; j++) if (bus.rn_valid[j] && bus.rn_dst_ena[j]) nalloc++;
    e_ready = (e_free >= nalloc) && !bus.flush;
    for (int a = 0; a < AR; a++) g_map[a] = m_spec_map[a];
    for (int j = 0; j < W; j++) begin
      e_psrc1[j] = 0;
      e_psrc2[j] = 0;
      e_pdst[j] = 0;
      e_pold[j] = 0;
      if (bus.rn_valid[j]) begin
        e_psrc1[j] = g_map[bus.rn_src1[j]];
        e_psrc2[j] = g_map[bus.rn_src2[j]];
        if (bus.rn_dst_ena[j]) begin
          e_pold[j] = g_map[bus.rn_dst[j]];
          e_pdst[j] = (slot < freeq.size()) ? freeq[slot] : 0;
          slot++;
          g_map[bus.rn_dst[j]] = e_pdst[j];
        end
      end
    end
  endfunction

  function automatic void model_commit();
    bit acc;
    acc = bus.ena && e_ready && (bus.rn_valid != '0);
    if (acc) begin
      for (int j = 0; j < W; j++) begin
        if (bus.rn_valid[j] && bus.rn_dst_ena[j]) begin
          m_spec_cl[e_pdst[j]] = 1'b1;
          rob.push_back('{int'(bus.rn_dst[j]), e_pdst[j], e_pold[j]});
        end
      end
      for (int a = 0; a < AR; a++) m_spec_map[a] = g_map[a];
    end
    for (int j = 0; j < W; j++) begin
      if (bus.rt_valid[j]) begin
        m_com_map[bus.rt_dst[j]] = int'(bus.rt_pdst[j]);
        m_com_cl[bus.rt_pdst[j]] = 1'b1;
        m_com_cl[bus.rt_pold[j]] = 1'b0;
        m_spec_cl[bus.rt_pold[j]] = 1'b0;
      end
    end
    if (bus.flush) begin
      for (int a = 0; a < AR; a++) m_spec_map[a] = m_com_map[a];
      for (int p = 0; p < PR; p++) m_spec_cl[p] = m_com_cl[p];
    end
  endfunction

  task automatic drive_idle();
    bus.ena = 1'b0;
    bus.rn_valid = '0;
    bus.rn_src1 = '0;
    bus.rn_src2 = '0;
    bus.rn_dst = '0;
    bus.rn_dst_ena = '0;
    bus.rt_valid = '0;
    bus.rt_dst = '0;
    bus.rt_pdst = '0;
    bus.rt_pold = '0;
    bus.flush = 1'b0;
  endtask

  // One clock edge with the model following; inputs return to idle afterwards.
  task automatic tick();
    model_expect();
    @(posedge clk);
    model_commit();
    #1;
    drive_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    model_reset();
    rob.delete();
    #2;
    rst = 1'b1;
  endtask

  // Read spec_map[r] through lane 0's source port without renaming anything.
  task automatic peek(input int r, output int v);
    @(negedge clk);
    drive_idle();
    bus.rn_valid[0] = 1'b1;
    bus.rn_src1[0] = arch_reg_t'(r);
    #1;
    v = int'(bus.rn_psrc1[0]);
  endtask

  task automatic rename1(input int dst, input int src);
    bus.ena = 1'b1;
    bus.rn_valid[0] = 1'b1;
    bus.rn_dst_ena[0] = 1'b1;
    bus.rn_dst[0] = arch_reg_t'(dst);
    bus.rn_src1[0] = arch_reg_t'(src);
  endtask

  task automatic test_reset();
    int v;
    drive_idle();
    rst = 1'b0;
    model_reset();
    #12;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.free_count !== 6'(PR - AR)) begin
      miscompares++;
      $display("FAIL reset_free_count: got %0d want %0d", bus.free_count, PR - AR);
    end
    vectors++;
    if (bus.rn_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %0b want 1", bus.rn_ready);
    end
    for (int r = 0; r < AR; r += 5) begin
      peek(r, v);
      vectors++;
      if (v !== r) begin
        miscompares++;
        $display("FAIL reset_identity[%0d]: got %0d want %0d", r, v, r);
      end
    end
  endtask

  task automatic test_single_rename();
    int v;
    do_reset();
    @(negedge clk);
    rename1(3, 3);
    #1;
    vectors++;
    if (bus.rn_psrc1[0] !== 5'd3 || bus.rn_pdst[0] !== 5'd16 || bus.rn_pold[0] !== 5'd3) begin
      miscompares++;
      $display("FAIL single_rename: got psrc1=%0d pdst=%0d pold=%0d want 3 16 3",
               bus.rn_psrc1[0], bus.rn_pdst[0], bus.rn_pold[0]);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.free_count !== 6'd15) begin
      miscompares++;
      $display("FAIL single_free_count: got %0d want 15", bus.free_count);
    end
    peek(3, v);
    vectors++;
    if (v !== 16) begin
      miscompares++;
      $display("FAIL single_map3: got %0d want 16", v);
    end
  endtask

  task automatic test_bypass();
    int v;
    do_reset();
    @(negedge clk);
    bus.ena = 1'b1;
    bus.rn_valid = 2'b11;
    bus.rn_dst_ena = 2'b11;
    bus.rn_dst[0] = arch_reg_t'(5);
    bus.rn_src1[1] = arch_reg_t'(5);
    bus.rn_dst[1] = arch_reg_t'(5);
    #1;
    vectors++;
    if (bus.rn_pdst[0] !== 5'd16 || bus.rn_psrc1[1] !== 5'd16 || bus.rn_pold[1] !== 5'd16
        || bus.rn_pdst[1] !== 5'd17) begin
      miscompares++;
      $display("FAIL bypass_lanes: got pdst0=%0d psrc1_1=%0d pold1=%0d pdst1=%0d want 16 16 16 17",
               bus.rn_pdst[0], bus.rn_psrc1[1], bus.rn_pold[1], bus.rn_pdst[1]);
    end
    tick();
    peek(5, v);
    vectors++;
    if (v !== 17) begin
      miscompares++;
      $display("FAIL bypass_map5: got %0d want 17", v);
    end
    vectors++;
    if (bus.free_count !== 6'd14) begin
      miscompares++;
      $display("FAIL bypass_free_count: got %0d want 14", bus.free_count);
    end
  endtask

  task automatic test_exhaustion();
    int v;
    do_reset();
    for (int i = 0; i < PR - AR; i++) begin
      @(negedge clk);
      rename1(i % AR, 0);
      #1;
      vectors++;
      if (bus.rn_pdst[0] !== 5'(AR + i)) begin
        miscompares++;
        $display("FAIL exhaust_pdst[%0d]: got %0d want %0d", i, bus.rn_pdst[0], AR + i);
      end
      tick();
    end
    @(negedge clk);
    rename1(2, 0);
    #1;
    vectors++;
    if (bus.free_count !== 6'd0 || bus.rn_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL exhaust_full: got free=%0d ready=%0b want 0 0", bus.free_count, bus.rn_ready);
    end
    tick();
    peek(2, v);
    vectors++;
    if (v !== 18) begin
      miscompares++;
      $display("FAIL exhaust_rejected_map2: got %0d want 18", v);
    end
    @(negedge clk);
    drive_idle();
    bus.ena = 1'b1;
    bus.rn_valid = 2'b11;
    #1;
    vectors++;
    if (bus.rn_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL exhaust_nonwriting_ready: got %0b want 1", bus.rn_ready);
    end
    tick();
  endtask

  task automatic test_retire();
    do_reset();
    @(negedge clk);
    rename1(3, 0);
    tick();
    @(negedge clk);
    rename1(7, 0);
    bus.rt_valid[0] = 1'b1;
    bus.rt_dst[0] = arch_reg_t'(3);
    bus.rt_pdst[0] = phys_reg_t'(16);
    bus.rt_pold[0] = phys_reg_t'(3);
    #1;
    vectors++;
    if (bus.rn_pdst[0] !== 5'd17) begin
      miscompares++;
      $display("FAIL retire_same_cycle_pdst: got %0d want 17", bus.rn_pdst[0]);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.free_count !== 6'd15) begin
      miscompares++;
      $display("FAIL retire_free_count: got %0d want 15", bus.free_count);
    end
    rename1(8, 0);
    #1;
    vectors++;
    if (bus.rn_pdst[0] !== 5'd3) begin
      miscompares++;
      $display("FAIL retire_reuse_pdst: got %0d want 3", bus.rn_pdst[0]);
    end
    tick();
  endtask

  task automatic test_flush();
    int v;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      rename1(i, 0);
      tick();
    end
    @(negedge clk);
    bus.rt_valid[0] = 1'b1;
    bus.rt_dst[0] = arch_reg_t'(1);
    bus.rt_pdst[0] = phys_reg_t'(16);
    bus.rt_pold[0] = phys_reg_t'(1);
    tick();
    @(negedge clk);
    rename1(9, 0);
    bus.flush = 1'b1;
    #1;
    vectors++;
    if (bus.rn_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got %0b want 0", bus.rn_ready);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.free_count !== 6'(PR - AR)) begin
      miscompares++;
      $display("FAIL flush_free_count: got %0d want %0d", bus.free_count, PR - AR);
    end
    peek(1, v);
    vectors++;
    if (v !== 16) begin
      miscompares++;
      $display("FAIL flush_map1: got %0d want 16", v);
    end
    peek(4, v);
    vectors++;
    if (v !== 4) begin
      miscompares++;
      $display("FAIL flush_map4: got %0d want 4", v);
    end
    peek(9, v);
    vectors++;
    if (v !== 9) begin
      miscompares++;
      $display("FAIL flush_map9: got %0d want 9", v);
    end
  endtask

  task automatic test_reset_mid_group();
    do_reset();
    @(negedge clk);
    rename1(3, 0);
    tick();
    @(negedge clk);
    rename1(3, 3);
    #2;
    rst = 1'b0;
    model_reset();
    rob.delete();
    #1;
    vectors++;
    if (bus.free_count !== 6'(PR - AR) || bus.rn_psrc1[0] !== 5'd3) begin
      miscompares++;
      $display("FAIL midreset_async: got free=%0d psrc1=%0d want %0d 3",
               bus.free_count, bus.rn_psrc1[0], PR - AR);
    end
    drive_idle();
    #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.free_count !== 6'(PR - AR)) begin
      miscompares++;
      $display("FAIL midreset_dropped: got %0d want %0d", bus.free_count, PR - AR);
    end
  endtask

  task automatic test_random();
    int k;
    bit fl;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive_idle();
      bus.ena = ($urandom_range(0, 7) != 0);
      for (int j = 0; j < W; j++) begin
        bus.rn_valid[j] = ($urandom_range(0, 3) != 0);
        bus.rn_dst_ena[j] = ($urandom_range(0, 3) != 0);
        bus.rn_src1[j] = arch_reg_t'($urandom_range(0, AR - 1));
        bus.rn_src2[j] = arch_reg_t'($urandom_range(0, AR - 1));
        bus.rn_dst[j] = arch_reg_t'($urandom_range(0, AR - 1));
      end
      fl = ($urandom_range(0, 29) == 0);
      bus.flush = fl;
      k = $urandom_range(0, W);
      if (k > rob.size()) k = rob.size();
      for (int j = 0; j < k; j++) begin
        bus.rt_valid[j] = 1'b1;
        bus.rt_dst[j] = arch_reg_t'(rob[j].dst);
        bus.rt_pdst[j] = phys_reg_t'(rob[j].pdst);
        bus.rt_pold[j] = phys_reg_t'(rob[j].pold);
      end
      model_expect();
      #1;
      vectors++;
      if (bus.rn_ready !== e_ready || bus.free_count !== 6'(e_free)) begin
        miscompares++;
        $display("FAIL rand_ready_free cycle %0d: got ready=%0b free=%0d want %0b %0d",
                 c, bus.rn_ready, bus.free_count, e_ready, e_free);
      end
      if (e_ready) begin
        for (int j = 0; j < W; j++) begin
          vectors++;
          if (bus.rn_psrc1[j] !== 5'(e_psrc1[j]) || bus.rn_psrc2[j] !== 5'(e_psrc2[j])
              || bus.rn_pdst[j] !== 5'(e_pdst[j]) || bus.rn_pold[j] !== 5'(e_pold[j])) begin
            miscompares++;
            $display("FAIL rand_lane%0d cycle %0d: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                     j, c, bus.rn_psrc1[j], bus.rn_psrc2[j], bus.rn_pdst[j], bus.rn_pold[j],
                     e_psrc1[j], e_psrc2[j], e_pdst[j], e_pold[j]);
          end
        end
      end
      tick();
      for (int j = 0; j < k; j++) void'(rob.pop_front());
      if (fl) rob.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_rename();
    test_bypass();
    test_exhaustion();
    test_retire();
    test_flush();
    test_reset_mid_group();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
